// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

    // Widest data word a frame may carry; the parity helper is sized to it.
    localparam int MAX_DATA_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Per-frame line configuration, captured when a word leaves the FIFO.
    typedef struct packed {
        logic par_en;
        logic par_odd;
        logic two_stop;
    } frame_cfg_t;

    // Parity bit for a word (zero-extended, so narrower words are unaffected).
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering words ahead of the serialiser.
module uart_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_q];
    assign count   = cnt_q;

    // Storage write; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end

    // Pointers wrap naturally at DEPTH (power of two); count separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready FIFO front end, registered serial output.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          par_en,
    input  logic                          par_odd,
    input  logic                          two_stop,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

    tx_state_e         state_q;
    frame_cfg_t        cfg_q, cfg_d;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic              tx_q;
    logic [BW-1:0]     baud_q;
    logic [IW-1:0]     idx_q;

    logic [DATA_W-1:0] head;
    logic              full, empty, push, pop;
    logic              baud_done, stop_done;

    assign cfg_d     = '{par_en: par_en, par_odd: par_odd, two_stop: two_stop};
    assign baud_done = (baud_q == BAUD_LAST);
    // With two stop bits idx_q marks the second stop period.
    assign stop_done = baud_done && (!cfg_q.two_stop || idx_q != '0);
    assign push      = s_valid && !full;
    // Pop either from idle or at the very last stop cycle, so frames run back to back.
    assign pop       = !empty && ((state_q == IDLE) || (state_q == STOP && stop_done));

    uart_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (s_data),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign s_ready = !full;
    assign tx_out  = tx_q;
    assign busy    = (state_q != IDLE) || (fifo_count != '0);

    // Frame sequencer: walks start/data/parity/stop and drives the registered line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            baud_q  <= '0;
            idx_q   <= '0;
        end else begin
            baud_q <= baud_q + BW'(1);
            case (state_q)
                IDLE: baud_q <= '0;
                START: if (baud_done) begin
                    state_q <= DATA;
                    tx_q    <= shift_q[0];
                    baud_q  <= '0;
                    idx_q   <= '0;
                end
                DATA: if (baud_done) begin
                    baud_q <= '0;
                    if (idx_q == IDX_LAST) begin
                        if (cfg_q.par_en) begin
                            state_q <= PARITY;
                            tx_q    <= par_q;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                            idx_q   <= '0;
                        end
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        tx_q    <= shift_q[1];
                        shift_q <= shift_q >> 1;
                    end
                end
                PARITY: if (baud_done) begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    idx_q   <= '0;
                end
                STOP: if (baud_done) begin
                    baud_q <= '0;
                    if (stop_done) state_q <= IDLE;
                    else           idx_q   <= idx_q + IW'(1);
                end
                default: state_q <= IDLE;
            endcase
            // Loading a new word overrides the idle/stop outcome above.
            if (pop) begin
                state_q <= START;
                shift_q <= head;
                cfg_q   <= cfg_d;
                par_q   <= parity_bit(MAX_DATA_W'(head), par_odd);
                tx_q    <= 1'b0;
                baud_q  <= '0;
                idx_q   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: vector table, hand sequences and random batches vs a frame-level model.
module tb_uart_tx_param;
    localparam int DW   = 8;
    localparam int C    = 4;
    localparam int D    = 4;
    localparam int MAXC = 1500;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0, par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0;
    logic       s_ready, tx_out, busy;
    logic [2:0] fifo_count;

    uart_tx_param #(.DATA_W(DW), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .par_en(par_en), .par_odd(par_odd), .two_stop(two_stop),
        .tx_out(tx_out), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Batch stimulus and captured DUT trace.
    logic [7:0] words [16];
    int         gaps [16];
    int         push_at [16], start_at [16], end_at [16];
    int         pushed, ncyc;
    logic       tx_r [MAXC], busy_r [MAXC], rdy_r [MAXC];
    int         cnt_r [MAXC];

    // Line level of bit b of a frame, straight from the frame format.
    function automatic logic frame_bit(input logic [7:0] w, input int b, input bit pe, input bit po);
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
        if (b == DW + 1 && pe) return (^w) ^ po;
        return 1'b1;
    endfunction

    // Push n words (with idle gaps), capture one sample per cycle until the block drains.
    task automatic run_batch(input int n, input bit pe, input bit po, input bit ts, input int flip_cyc);
        int  idx, wait_left;
        bit  hs;
        @(negedge clk);
        par_en = pe; par_odd = po; two_stop = ts;
        idx = 0; wait_left = gaps[0]; pushed = 0; ncyc = 0;
        s_valid = (wait_left == 0); s_data = words[0];
        for (int k = 0; k < MAXC; k++) begin
            hs = s_valid && s_ready;
            @(negedge clk);
            tx_r[k] = tx_out; busy_r[k] = busy; rdy_r[k] = s_ready; cnt_r[k] = int'(fifo_count);
            ncyc = k + 1;
            if (hs) begin
                push_at[idx] = k; idx++; pushed = idx;
                wait_left = (idx < n) ? gaps[idx] : 0;
            end else if (!s_valid && wait_left > 0) begin
                wait_left--;
            end
            s_valid = (idx < n) && (wait_left == 0);
            if (idx < n) s_data = words[idx];
            if (k == flip_cyc) two_stop = !two_stop;
            if (idx == n && !busy && k > 0) break;
        end
        s_valid = 1'b0;
        check("batch drained", int'(busy_r[ncyc-1]), 0);
    endtask

    // Frame-level model: frame j starts when its word is present and the line is free.
    task automatic model_check(input string name, input int n, input bit pe, input bit po, input bit ts);
        int L, prev_end, bad_tx, bad_busy, bad_cnt, bad_rdy;
        L = (DW + 2 + pe + ts) * C;
        check({name, " accepted"}, pushed, n);
        prev_end = 0;
        for (int j = 0; j < pushed; j++) begin
            start_at[j] = (push_at[j] + 1 > prev_end) ? push_at[j] + 1 : prev_end;
            end_at[j]   = start_at[j] + L;
            prev_end    = end_at[j];
        end
        bad_tx = 0; bad_busy = 0; bad_cnt = 0; bad_rdy = 0;
        for (int k = 0; k < ncyc; k++) begin
            logic etx;
            bit   inf;
            int   ec;
            etx = 1'b1; inf = 0; ec = 0;
            for (int j = 0; j < pushed; j++) begin
                if (push_at[j] <= k) ec++;
                if (start_at[j] <= k) ec--;
                if (k >= start_at[j] && k < end_at[j]) begin
                    inf = 1;
                    etx = frame_bit(words[j], (k - start_at[j]) / C, pe, po);
                end
            end
            if (tx_r[k] !== etx) bad_tx++;
            if (busy_r[k] !== (inf || ec != 0)) bad_busy++;
            if (cnt_r[k] != ec) bad_cnt++;
            if (rdy_r[k] !== (ec != D)) bad_rdy++;
        end
        check({name, " tx mismatches"}, bad_tx, 0);
        check({name, " busy mismatches"}, bad_busy, 0);
        check({name, " count mismatches"}, bad_cnt, 0);
        check({name, " ready mismatches"}, bad_rdy, 0);
        if (pushed > 0) check({name, " drain cycle"}, ncyc - 1, end_at[pushed-1]);
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          pe, po, ts;
        int          flip;
        int          nbits;
        logic [11:0] bits;
        int          len;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int saw_full, got, bad;
        tbl[0] = '{8'h55, 0, 0, 0, -1, 10, 12'h2AA, 40};
        tbl[1] = '{8'h07, 1, 0, 0, -1, 11, 12'h60E, 44};
        tbl[2] = '{8'h00, 1, 1, 0, -1, 11, 12'h600, 44};
        tbl[3] = '{8'hA3, 0, 0, 1,  6, 11, 12'h746, 44};
        tbl[4] = '{8'hA3, 1, 1, 1, -1, 12, 12'hF46, 48};

        // Reset state
        #12;
        check("reset tx_out", int'(tx_out), 1);
        check("reset s_ready", int'(s_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset fifo_count", int'(fifo_count), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Vector table: single frames, mid-bit decode and frame length
        for (int v = 0; v < 5; v++) begin
            logic [11:0] dec;
            words[0] = tbl[v].data; gaps[0] = 0;
            run_batch(1, tbl[v].pe, tbl[v].po, tbl[v].ts, tbl[v].flip);
            dec = '0;
            for (int b = 0; b < tbl[v].nbits; b++) dec[b] = tx_r[1 + b*C + C/2];
            check($sformatf("vec%0d line before fall", v), int'(tx_r[0]), 1);
            check($sformatf("vec%0d fall one cycle after push", v), int'(tx_r[1]), 0);
            check($sformatf("vec%0d mid-bit pattern", v), int'(dec), int'(tbl[v].bits));
            check($sformatf("vec%0d frame length", v), ncyc - 2, tbl[v].len);
            model_check($sformatf("vec%0d", v), 1, tbl[v].pe, tbl[v].po, tbl[v].ts);
        end

        // Back-to-back five words: fill, contiguous frames, order
        for (int j = 0; j < 5; j++) begin words[j] = 8'(j + 1); gaps[j] = 0; end
        run_batch(5, 0, 0, 0, -1);
        model_check("b2b", 5, 0, 0, 0);
        saw_full = 0;
        for (int k = 0; k < ncyc; k++) if (cnt_r[k] == 4 && !rdy_r[k]) saw_full = 1;
        check("b2b ready low when full", saw_full, 1);
        for (int j = 0; j < 5; j++) begin
            got = 0;
            for (int i = 0; i < DW; i++) got |= int'(tx_r[1 + j*40 + (1+i)*C + C/2]) << i;
            check($sformatf("b2b word %0d order", j), got, j + 1);
        end
        check("b2b end cycle", ncyc - 1, 1 + 5*40);
        check("b2b final count", cnt_r[ncyc-1], 0);

        // Push coinciding with the idle pop keeps the count at one; no gap between frames
        words[0] = 8'h3C; words[1] = 8'hC3; gaps[0] = 0; gaps[1] = 0;
        run_batch(2, 0, 0, 0, -1);
        model_check("pushpop", 2, 0, 0, 0);
        check("pushpop count after first push", cnt_r[0], 1);
        check("pushpop count after simultaneous push/pop", cnt_r[1], 1);
        check("pushpop second start", int'(tx_r[41]), 0);

        // Random batches against the model
        for (int r = 0; r < 6; r++) begin
            int n;
            bit pe, po, ts;
            n = $urandom_range(1, 6);
            pe = 1'($urandom_range(0, 1)); po = 1'($urandom_range(0, 1)); ts = 1'($urandom_range(0, 1));
            for (int j = 0; j < n; j++) begin
                words[j] = 8'($urandom);
                gaps[j]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : 0;
            end
            run_batch(n, pe, po, ts, -1);
            model_check($sformatf("rand%0d", r), n, pe, po, ts);
        end

        // Reset during data bit 3 of 0xF0 with two words queued
        @(negedge clk);
        par_en = 0; par_odd = 0; two_stop = 0;
        s_valid = 1'b1; s_data = 8'hF0;
        @(negedge clk); s_data = 8'h11;
        @(negedge clk); s_data = 8'h22;
        @(negedge clk); s_valid = 1'b0;
        repeat (16) @(negedge clk);
        check("abort pre-reset tx (data bit 3)", int'(tx_out), 0);
        check("abort pre-reset queued", int'(fifo_count), 2);
        #2 rst_n = 1'b0;
        #1;
        check("abort tx high immediately", int'(tx_out), 1);
        check("abort fifo_count", int'(fifo_count), 0);
        check("abort busy", int'(busy), 0);
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("abort no further frames", bad, 0);
        check("abort s_ready after release", int'(s_ready), 1);
        check("abort fifo_count after release", int'(fifo_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
